// File: rtl/medidor_osc_pspl.sv
// Oscillator edge counter behind the PS-PL sync/ack four-phase handshake.
// Optional build macro MEDIDOR_OVERFLOW_FLAG_EN turns the result MSB into a sticky overflow flag.
module medidor_osc_pspl #(
    parameter int BUFFER_IN_WIDTH  = 16,
    parameter int BUFFER_OUT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        osc_in,
    input  logic                        sync,
    output logic                        ack,
    input  logic [BUFFER_IN_WIDTH-1:0]  buffer_in,
    output logic [BUFFER_OUT_WIDTH-1:0] buffer_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [BUFFER_IN_WIDTH-1:0]  REM_ONE = BUFFER_IN_WIDTH'(1);
    localparam logic [BUFFER_OUT_WIDTH-1:0] CNT_ONE = BUFFER_OUT_WIDTH'(1);

    state_t                      state_reg, state_next;
    logic                        osc_meta_reg, osc_sync_reg, osc_prev_reg, edge_reg;
    logic [BUFFER_IN_WIDTH-1:0]  remaining_reg, remaining_next;
    logic [BUFFER_OUT_WIDTH-1:0] count_reg, count_next, count_inc;
    logic                        ack_reg, ack_next;
    logic [BUFFER_OUT_WIDTH-1:0] buffer_out_reg, buffer_out_next;

    // Count value after this cycle's edge, saturating instead of wrapping.
`ifdef MEDIDOR_OVERFLOW_FLAG_EN
    localparam logic [BUFFER_OUT_WIDTH-2:0] LOW_MAX = '1;
    localparam logic [BUFFER_OUT_WIDTH-2:0] LOW_ONE = (BUFFER_OUT_WIDTH-1)'(1);

    always_comb begin
        count_inc = count_reg;
        if (edge_reg) begin
            if (count_reg[BUFFER_OUT_WIDTH-2:0] == LOW_MAX)
                count_inc[BUFFER_OUT_WIDTH-1] = 1'b1;
            else
                count_inc[BUFFER_OUT_WIDTH-2:0] = count_reg[BUFFER_OUT_WIDTH-2:0] + LOW_ONE;
        end
    end
`else
    always_comb begin
        count_inc = count_reg;
        if (edge_reg && (count_reg != '1))
            count_inc = count_reg + CNT_ONE;
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            osc_meta_reg   <= 1'b0;
            osc_sync_reg   <= 1'b0;
            osc_prev_reg   <= 1'b0;
            edge_reg       <= 1'b0;
            remaining_reg  <= '0;
            count_reg      <= '0;
            ack_reg        <= 1'b0;
            buffer_out_reg <= '0;
        end else begin
            state_reg      <= state_next;
            osc_meta_reg   <= osc_in;
            osc_sync_reg   <= osc_meta_reg;
            osc_prev_reg   <= osc_sync_reg;
            edge_reg       <= osc_sync_reg & ~osc_prev_reg;
            remaining_reg  <= remaining_next;
            count_reg      <= count_next;
            ack_reg        <= ack_next;
            buffer_out_reg <= buffer_out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        count_next     = count_reg;
        case (state_reg)
            IDLE: begin
                if (sync) begin
                    count_next     = '0;
                    remaining_next = buffer_in;
                    state_next     = (buffer_in == '0) ? DONE : MEASURE;
                end
            end
            MEASURE: begin
                // Dropping sync mid-window abandons the measurement.
                if (!sync) begin
                    state_next = IDLE;
                end else begin
                    remaining_next = remaining_reg - REM_ONE;
                    count_next     = count_inc;
                    if (remaining_reg == REM_ONE)
                        state_next = DONE;
                end
            end
            DONE: begin
                if (!sync)
                    state_next = RELEASE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ack is registered: it rises with entry into DONE after a window and stays up
    // through the edge where sync is first seen low.
    always_comb begin
        ack_next        = 1'b0;
        buffer_out_next = buffer_out_reg;
        case (state_reg)
            IDLE: begin
                if (sync && (buffer_in == '0))
                    buffer_out_next = '0;
            end
            MEASURE: begin
                if (sync && (remaining_reg == REM_ONE)) begin
                    ack_next        = 1'b1;
                    buffer_out_next = count_inc;
                end
            end
            DONE: begin
                ack_next = 1'b1;
            end
            default: begin
                ack_next = 1'b0;
            end
        endcase
    end

    assign ack        = ack_reg;
    assign buffer_out = buffer_out_reg;

endmodule

// File: tb/tb_medidor_osc_pspl.sv
// Scoreboard bench for medidor_osc_pspl: one task per scenario, 8-bit result width.
module tb_medidor_osc_pspl;

    logic        clock;
    logic        resetn;
    logic        osc_in;
    logic        sync;
    logic        ack;
    logic [15:0] buffer_in;
    logic [7:0]  buffer_out;

    int checks = 0;
    int errors = 0;
    int osc_half = 0;
    int osc_cnt = 0;
    logic [7:0] exp_q[$];

    medidor_osc_pspl #(
        .BUFFER_IN_WIDTH (16),
        .BUFFER_OUT_WIDTH(8)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .osc_in    (osc_in),
        .sync      (sync),
        .ack       (ack),
        .buffer_in (buffer_in),
        .buffer_out(buffer_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Oscillator toggles every osc_half clocks (0 = stopped).
    always @(negedge clock) begin
        if (osc_half > 0) begin
            if (osc_cnt >= osc_half - 1) begin
                osc_cnt <= 0;
                osc_in  <= ~osc_in;
            end else begin
                osc_cnt <= osc_cnt + 1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start_req(input int w);
        buffer_in = 16'(w);
        sync = 1'b1;
    endtask

    // Returns clocks from the edge that samples sync to the edge where ack is seen.
    task automatic wait_ack(input int limit, output int lat);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!ack && n <= limit);
        lat = n - 1;
    endtask

    task automatic release_sync();
        sync = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(3);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b expected 0", ack); end
        checks++;
        if (buffer_out !== 8'd0) begin errors++; $display("FAIL reset_buf: got %0d expected 0", buffer_out); end
        resetn = 1'b1;
        cyc(2);
        $display("test_reset: ack=%0b buffer_out=%0d", ack, buffer_out);
    endtask

    task automatic test_zero_window();
        int lat;
        logic [7:0] e;
        exp_q.push_back(8'd0);
        start_req(0);
        wait_ack(20, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL zero_count: got %0d expected %0d", buffer_out, e); end
        sync = 1'b0;
        cyc(1);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL zero_ack_hold: got %0b expected 1", ack); end
        cyc(1);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL zero_ack_drop: got %0b expected 0", ack); end
        $display("test_zero_window: latency=%0d buffer_out=%0d", lat, buffer_out);
    endtask

    task automatic test_window_one();
        int lat;
        logic [7:0] e;
        exp_q.push_back(8'd0);
        start_req(1);
        wait_ack(20, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL w1_latency: got %0d expected 1", lat); end
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL w1_count: got %0d expected %0d", buffer_out, e); end
        release_sync();
        $display("test_window_one: latency=%0d buffer_out=%0d", lat, buffer_out);
    endtask

    task automatic test_nominal();
        int lat;
        logic [7:0] e;
        osc_half = 2;
        cyc(12);
        exp_q.push_back(8'd25);
        start_req(100);
        cyc(1);
        buffer_in = 16'd5;
        wait_ack(200, lat);
        lat = lat + 1;
        e = exp_q.pop_front();
        checks++;
        if (lat !== 100) begin errors++; $display("FAIL nominal_latency: got %0d expected 100", lat); end
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL nominal_count: got %0d expected %0d", buffer_out, e); end
        release_sync();
        $display("test_nominal: latency=%0d buffer_out=%0d", lat, buffer_out);
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        start_req(500);
        cyc(200);
        sync = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (ack) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_ack: got %0d ack cycles expected 0", seen); end
        checks++;
        if (buffer_out !== 8'd25) begin errors++; $display("FAIL abort_buf: got %0d expected 25", buffer_out); end
        $display("test_abort: ack_cycles=%0d buffer_out=%0d", seen, buffer_out);
    endtask

    task automatic test_saturation();
        int lat;
        logic [7:0] e;
        osc_half = 1;
        cyc(6);
        // 500 edges overflow 8 bits: full-count mode saturates at 255, flag mode gives flag=1,count=127.
        exp_q.push_back(8'hFF);
        start_req(1000);
        wait_ack(1100, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 1000) begin errors++; $display("FAIL sat_latency: got %0d expected 1000", lat); end
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL sat_count: got %0h expected %0h", buffer_out, e); end
        release_sync();
        $display("test_saturation: latency=%0d buffer_out=%0h", lat, buffer_out);
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [7:0] e;
        osc_half = 2;
        cyc(12);
        start_req(100);
        cyc(50);
        resetn = 1'b0;
        cyc(1);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %0b expected 0", ack); end
        checks++;
        if (buffer_out !== 8'd0) begin errors++; $display("FAIL rstmid_buf: got %0d expected 0", buffer_out); end
        resetn = 1'b1;
        sync = 1'b0;
        cyc(12);
        exp_q.push_back(8'd25);
        start_req(100);
        wait_ack(200, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 100) begin errors++; $display("FAIL rstmid_latency: got %0d expected 100", lat); end
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL rstmid_count: got %0d expected %0d", buffer_out, e); end
        release_sync();
        $display("test_reset_mid: latency=%0d buffer_out=%0d", lat, buffer_out);
    endtask

    task automatic test_back_to_back();
        int lat;
        int drops;
        int changes;
        logic [7:0] e;
        osc_half = 2;
        cyc(4);
        exp_q.push_back(8'd25);
        start_req(100);
        wait_ack(200, lat);
        e = exp_q.pop_front();
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", buffer_out, e); end
        drops = 0;
        changes = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (ack !== 1'b1) drops++;
            if (buffer_out !== e) changes++;
        end
        checks++;
        if (drops !== 0) begin errors++; $display("FAIL b2b_ack_held: got %0d low cycles expected 0", drops); end
        checks++;
        if (changes !== 0) begin errors++; $display("FAIL b2b_no_retrigger: got %0d changed cycles expected 0", changes); end
        release_sync();
        cyc(3);
        osc_half = 1;
        cyc(6);
        exp_q.push_back(8'd20);
        start_req(40);
        wait_ack(100, lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 40) begin errors++; $display("FAIL b2b_latency: got %0d expected 40", lat); end
        checks++;
        if (buffer_out !== e) begin errors++; $display("FAIL b2b_second: got %0d expected %0d", buffer_out, e); end
        release_sync();
        $display("test_back_to_back: latency=%0d buffer_out=%0d", lat, buffer_out);
    endtask

    initial begin
        resetn    = 1'b0;
        sync      = 1'b0;
        buffer_in = 16'd0;
        osc_in    = 1'b0;
        test_reset();
        test_zero_window();
        test_window_one();
        test_nominal();
        test_abort();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
